// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache: 16 one-word frames between fetch and memory.
// Hits return combinationally; a miss fetches one word, fills the frame, then hits.
module icache_direct #(
    parameter int NFRAMES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    input  logic             flush,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int ITAG_W = 26;
    localparam int IIDX_W = 4;
    localparam int IBYT_W = 2;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t              r_state;
    logic [31:0]         r_iaddr;
    logic                r_iren;
    logic [CNT_W-1:0]    r_hit_count;
    logic [CNT_W-1:0]    r_miss_count;
    logic [NFRAMES-1:0]  r_valid;
    logic [ITAG_W-1:0]   r_tag  [NFRAMES];
    logic [31:0]         r_data [NFRAMES];

    icachef_t            w_req;
    icachef_t            w_fa;
    logic                w_match;
    logic                w_miss;
    logic                w_fill;
    logic                w_unused;

    assign w_req    = imemaddr;
    assign w_fa     = r_iaddr;
    assign w_unused = ^{w_req.bytoff, w_fa.bytoff};

    assign w_match  = r_valid[w_req.idx] && (r_tag[w_req.idx] == w_req.tag);
    assign w_miss   = (r_state == IDLE) && imemREN && !w_match && !flush;
    // Flush discards a fill landing in the same cycle.
    assign w_fill   = (r_state == FETCH) && !iwait && !flush;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        ihit     = 1'b0;
        imemload = '0;
        if (!RST && (r_state == IDLE) && imemREN && w_match && !flush) begin
            ihit     = 1'b1;
            imemload = r_data[w_req.idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_iren       <= 1'b0;
            r_iaddr      <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (ihit && (r_hit_count != '1))
                r_hit_count <= r_hit_count + 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_state <= FETCH;
                        r_iren  <= 1'b1;
                        r_iaddr <= {imemaddr[31:2], 2'b00};
                        if (r_miss_count != '1)
                            r_miss_count <= r_miss_count + 1'b1;
                    end
                end
                FETCH: begin
                    if (flush || !iwait) begin
                        r_state <= IDLE;
                        r_iren  <= 1'b0;
                        r_iaddr <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            r_valid <= '0;
        else if (flush)
            r_valid <= '0;
        else if (w_fill)
            r_valid[w_fa.idx] <= 1'b1;
    end

    // NOTE: tag and data arrays are left unreset; the valid bits alone gate their use.
    always_ff @(posedge CLK) begin
        if (!RST && w_fill) begin
            r_tag[w_fa.idx]  <= w_fa.tag;
            r_data[w_fa.idx] <= iload;
        end
    end

    assign iREN       = r_iren;
    assign iaddr      = r_iaddr;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
